// File: rtl/dlatch_write_scheduler_if.sv
// Requester handshake and latch-bank signals for dlatch_write_scheduler.
// master = requesters plus latch bank (testbench side), slave = the scheduler.
interface dlatch_write_scheduler_if #(
  parameter int N_LATCH = 4,
  parameter int ADDR_W  = 2
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              d0;
  logic              d1;
  logic              ack0;
  logic              ack1;
  logic [N_LATCH-1:0] latch_c;
  logic              latch_d;
  logic [N_LATCH-1:0] latch_q;
  logic              busy;
  logic              err;

  modport master (
    output req0, req1, addr0, addr1, d0, d1, latch_q,
    input  ack0, ack1, latch_c, latch_d, busy, err
  );

  modport slave (
    input  req0, req1, addr0, addr1, d0, d1, latch_q,
    output ack0, ack1, latch_c, latch_d, busy, err
  );
endinterface

// File: rtl/dlatch_write_scheduler.sv
// Round-robin write sequencer for a gated D latch bank (setup / C pulse / hold).
// Optional readback compare of latch_q on the last hold cycle: DLATCH_READBACK_CHECK_EN.
//   state   | meaning
//   S_IDLE  | no write in flight, arbitrate requests
//   S_SETUP | D driven, C low (SETUP_CYC cycles after the grant cycle)
//   S_PULSE | D driven, C of the target latch high
//   S_HOLD  | D driven, C low
//   S_DONE  | ack (and err) pulse to the granted requester
module dlatch_write_scheduler #(
  parameter int N_LATCH   = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dlatch_write_scheduler_if.slave   bus
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr_q;
  logic               r_d_q;
  logic               r_gnt1;
  logic               r_ptr;
  logic [N_LATCH-1:0] r_latch_c;
  logic               r_latch_d;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_busy;
  logic               r_err;

  logic               w_gnt1;
  logic [N_LATCH-1:0] w_onehot;
  logic               w_addr_ok;
  logic               w_rb_bad;

  assign w_gnt1 = bus.req1 & (~bus.req0 | r_ptr);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (r_addr_q == ADDR_W'(i)) w_onehot[i] = 1'b1;
    end
  end

  // An address beyond the bank decodes to no latch at all.
  assign w_addr_ok = |w_onehot;

`ifdef DLATCH_READBACK_CHECK_EN
  assign w_rb_bad = w_addr_ok & ((|(bus.latch_q & w_onehot)) != r_d_q);
`else
  assign w_rb_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr_q  <= '0;
      r_d_q     <= 1'b0;
      r_gnt1    <= 1'b0;
      r_ptr     <= 1'b0;
      r_latch_c <= '0;
      r_latch_d <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.req0 | bus.req1) begin
            r_gnt1    <= w_gnt1;
            r_ptr     <= ~w_gnt1;
            r_addr_q  <= w_gnt1 ? bus.addr1 : bus.addr0;
            r_d_q     <= w_gnt1 ? bus.d1 : bus.d0;
            r_latch_d <= w_gnt1 ? bus.d1 : bus.d0;
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(SETUP_CYC);
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_latch_c <= w_onehot;
            r_cnt     <= CNT_W'(PULSE_CYC - 1);
            r_state   <= S_PULSE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_latch_c <= '0;
            r_cnt     <= CNT_W'(HOLD_CYC - 1);
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_ack0  <= ~r_gnt1;
            r_ack1  <= r_gnt1;
            r_err   <= ~w_addr_ok | w_rb_bad;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.latch_c = r_latch_c;
  assign bus.latch_d = r_latch_d;
  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.busy    = r_busy;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_dlatch_write_scheduler.sv
// Scoreboard bench for dlatch_write_scheduler with a behavioural latch bank.
// Build with DLATCH_READBACK_CHECK_EN defined to exercise the readback error path.
module tb_dlatch_write_scheduler;
  localparam int N_LATCH   = 3;
  localparam int ADDR_W    = 2;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
  localparam int LAT_ACK   = 2 + SETUP_CYC + PULSE_CYC + HOLD_CYC;
  localparam int GAP       = 3 + SETUP_CYC + PULSE_CYC + HOLD_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dlatch_write_scheduler_if #(.N_LATCH(N_LATCH), .ADDR_W(ADDR_W)) bus ();

  dlatch_write_scheduler #(
    .N_LATCH(N_LATCH), .ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Level-sensitive latch bank; force_mask pins selected Q outputs low.
  logic [N_LATCH-1:0] bank = '0;
  logic [N_LATCH-1:0] force_mask = '0;
  always @(bus.latch_c or bus.latch_d) begin
    for (int i = 0; i < N_LATCH; i++) begin
      if (bus.latch_c[i]) bank[i] = bus.latch_d;
    end
  end
  assign bus.latch_q = bank & ~force_mask;

  typedef struct {
    int id;
    int addr;
    bit d;
    bit err;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_ptr = 1'b0;

  task automatic check_eq(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit model_err(input int addr, input bit d);
    bit bad;
    bad = (addr >= N_LATCH);
`ifdef DLATCH_READBACK_CHECK_EN
    if (!bad && force_mask[addr] && d) bad = 1'b1;
`endif
    return bad;
  endfunction

  task automatic push_req(input int id, input int addr, input bit d, input int ecyc);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    e.d    = d;
    e.err  = model_err(addr, d);
    e.cyc  = ecyc;
    exp_q.push_back(e);
  endtask

  // Monitor: pulse shape on latch_c and scoreboard compare on every ack.
  int                 run = 0;
  logic [N_LATCH-1:0] run_pat = '0;
  logic [N_LATCH-1:0] seen_c = '0;
  exp_t               mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      run    = 0;
      seen_c = '0;
    end else begin
      if (bus.latch_c != '0) begin
        if (run == 0) run_pat = bus.latch_c;
        run++;
        check_eq("latch_c_onehot", $countones(bus.latch_c), 1);
        check_eq("latch_c_stable", int'(bus.latch_c), int'(run_pat));
        if (exp_q.size() > 0) check_eq("latch_d_during_c", int'(bus.latch_d), int'(exp_q[0].d));
        seen_c = seen_c | bus.latch_c;
      end else if (run > 0) begin
        check_eq("pulse_len", run, PULSE_CYC);
        run = 0;
      end
      if (bus.ack0 || bus.ack1) begin
        check_eq("ack_exclusive", int'(bus.ack0 & bus.ack1), 0);
        check_eq("ack_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("ack_id", int'(bus.ack1), mon_e.id);
          check_eq("ack_cycle", cyc, mon_e.cyc);
          check_eq("err", int'(bus.err), int'(mon_e.err));
          check_eq("busy_at_ack", int'(bus.busy), 1);
          check_eq("latch_c_target", int'(seen_c),
                   (mon_e.addr < N_LATCH) ? (1 << mon_e.addr) : 0);
          if (mon_e.addr < N_LATCH && !force_mask[mon_e.addr])
            check_eq("bank_q", int'(bus.latch_q[mon_e.addr]), int'(mon_e.d));
        end
        seen_c = '0;
      end else if (bus.err) begin
        check_eq("err_with_ack", int'(bus.ack0 | bus.ack1), 1);
      end
    end
  end

  // Drive until every expected ack has been seen and both reqs are released.
  task automatic wait_done(input int budget, input bit early);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || bus.req0 || bus.req1) && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (bus.ack0 || (early && bus.busy && bus.req0)) begin
        bus.req0  = 1'b0;
        bus.addr0 = ADDR_W'($urandom);
        bus.d0    = 1'($urandom);
      end
      if (bus.ack1 || (early && bus.busy && bus.req1)) begin
        bus.req1  = 1'b0;
        bus.addr1 = ADDR_W'($urandom);
        bus.d1    = 1'($urandom);
      end
    end
    check_eq("round_done", exp_q.size() + int'(bus.req0) + int'(bus.req1), 0);
    exp_q.delete();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_round(input bit r0, input bit r1, input int a0, input bit dv0,
                          input int a1, input bit dv1, input bit early);
    int c;
    bit first;
    bus.req0  = r0;
    bus.addr0 = ADDR_W'(a0);
    bus.d0    = dv0;
    bus.req1  = r1;
    bus.addr1 = ADDR_W'(a1);
    bus.d1    = dv1;
    c = cyc;
    if (r0 && r1) begin
      first = model_ptr;
      push_req(int'(first), first ? a1 : a0, first ? dv1 : dv0, c + LAT_ACK);
      push_req(int'(!first), first ? a0 : a1, first ? dv0 : dv1, c + LAT_ACK + GAP);
      model_ptr = first;
    end else begin
      push_req(int'(r1), r1 ? a1 : a0, r1 ? dv1 : dv0, c + LAT_ACK);
      model_ptr = !r1;
    end
    wait_done(60, early && !(r0 && r1));
  endtask

  initial begin
    int c;
    int n;
    bit r0;
    bit r1;
    bus.req0 = 1'b1; bus.addr0 = 2'd2; bus.d0 = 1'b1;
    bus.req1 = 1'b0; bus.addr1 = 2'd0; bus.d1 = 1'b0;
    rst_n = 1'b0;

    // Reset held with req0 pending: nothing may move.
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("reset_outputs",
               int'({bus.busy, bus.err, bus.ack0, bus.ack1, bus.latch_d, bus.latch_c}), 0);
    end
    rst_n = 1'b1;
    model_ptr = 1'b0;
    push_req(0, 2, 1'b1, cyc + LAT_ACK);
    model_ptr = 1'b1;
    wait_done(60, 1'b0);

    // Out-of-range address from requester 1.
    do_round(1'b0, 1'b1, 0, 1'b0, 3, 1'b1, 1'b0);

    // Contention, four back-to-back rounds.
    repeat (4) do_round(1'b1, 1'b1, 0, 1'b1, 3, 1'b0, 1'b0);

    // Reset in the middle of the C pulse, then the same write completes.
    bus.req0 = 1'b1; bus.addr0 = 2'd1; bus.d0 = 1'b1;
    push_req(0, 1, 1'b1, cyc + LAT_ACK);
    n = 0;
    while (bus.latch_c == '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("reached_pulse", int'(bus.latch_c != '0), 1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_eq("midrst_latch_c", int'(bus.latch_c), 0);
    check_eq("midrst_busy_ack", int'({bus.busy, bus.ack0, bus.ack1}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ptr = 1'b0;
    c = cyc;
    push_req(0, 1, 1'b1, c + LAT_ACK);
    model_ptr = 1'b1;
    wait_done(60, 1'b0);

    // Readback: latch 1 Q pinned low while writing a 1.
    bus.addr0 = 2'd0; bus.d0 = 1'b0;
    bus.req0 = 1'b0;
    force_mask = 3'b010;
    do_round(1'b1, 1'b0, 1, 1'b1, 0, 1'b0, 1'b0);
    force_mask = '0;

    // Randomised traffic, including early req drop and invalid addresses.
    repeat (40) begin
      n  = $urandom_range(1, 3);
      r0 = n[0];
      r1 = n[1];
      do_round(r0, r1, $urandom_range(0, 3), 1'($urandom),
               $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dlatch_write_scheduler.md
# dlatch_write_scheduler

Synchronous controller that owns a bank of gated D latches (inputs C, D; outputs Q, Qbar) and sequences every write into it. Two requesters share the bank through a round-robin arbiter; for each granted write the block drives the shared D line with setup and hold margin and pulses exactly one latch's C enable. It sits between the clocked control logic and the latch bank, so no other logic ever drives a latch C input directly.

## Interface
- N_LATCH, 4, number of latches in the bank (1..16)
- ADDR_W, 2, width of the latch address (≥ clog2(N_LATCH))
- SETUP_CYC, 1, cycles D is stable before C rises (≥ 1)
- PULSE_CYC, 2, cycles C is held high (≥ 1)
- HOLD_CYC, 1, cycles D is held after C falls (≥ 1)

Ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  write request from requester 0 / 1; held until ack
- addr0 / addr1  in  ADDR_W  target latch index; stable while req high
- d0 / d1  in  1  data to write; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1
- latch_c  out  N_LATCH  per-latch C enable, one-hot or zero
- latch_d  out  1  shared D line to all latches
- latch_q  in  N_LATCH  Q outputs of the bank (readback)
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse with ack on a failed or invalid write

## Operation
- FSM states: IDLE → SETUP → PULSE → HOLD → DONE → IDLE.
- IDLE: if any req is high, grant, capture addr/d into addr_q/d_q and go to SETUP. busy=0, latch_c=0.
- Arbitration: 1-bit pointer, reset value 0. One req high → grant it. Both high → grant the requester named by the pointer. After each grant the pointer points to the requester that was not granted.
- SETUP: latch_d=d_q, latch_c=0. Lasts SETUP_CYC cycles.
- PULSE: latch_d=d_q, latch_c=onehot(addr_q). Lasts PULSE_CYC cycles.
- HOLD: latch_d=d_q, latch_c=0. Lasts HOLD_CYC cycles.
- DONE: ack of the granted requester =1 for exactly one cycle. err may pulse in the same cycle. Next state is IDLE.
- Out-of-range address (addr_q ≥ N_LATCH): the full sequence runs with latch_c held at 0. err pulses with ack. Bank contents are unchanged.
- Requester rules:
  - A requester may drop req in the cycle after its ack.
  - If req is still high in IDLE, it is a new request.
  - A req dropped before its ack is not cancelled: the captured write completes.
- latch_c and latch_d are driven directly from flops, with no combinational decode after the register, so latch enables are glitch-free.
- latch_d holds its last written value in IDLE.
- A single duration counter, sized for the largest of SETUP_CYC, PULSE_CYC and HOLD_CYC, reloads on each state entry.

## Timing
- Reset values (rst_n low at an edge): state=IDLE, latch_c=0, latch_d=0, ack0=ack1=0, busy=0, err=0, pointer=0.
- Latency: req sampled high in IDLE at edge t gives ack high during cycle t+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+1. With defaults, ack is high in cycle t+6 and the next grant can be sampled at edge t+7.
- Throughput: one write per 3+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (7 with defaults).
- latch_c is high for exactly PULSE_CYC consecutive cycles per valid write and is never high for two latches at once.
- Reset mid-operation:
  - Next edge forces IDLE; latch_c drops to 0 at that edge.
  - No ack is issued.
  - The target latch content is undefined; the requester must reissue.
- A req arriving while busy waits. There is no queue beyond the req level itself.

## Configuration
- DLATCH_READBACK_CHECK_EN defined:
  - On the last HOLD cycle, the block samples latch_q[addr_q] and compares it with d_q.
  - A mismatch pulses err with ack in DONE.
- DLATCH_READBACK_CHECK_EN not defined:
  - latch_q is ignored.
  - err pulses only for out-of-range addresses.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req0=1 → all outputs 0; the first grant occurs only after rst_n=1.
- Single write: req0=1, addr0=2, d0=1 (defaults) → latch_c=4'b0100 for 2 cycles, starting 2 edges after sampling; latch_d=1 from SETUP through HOLD; ack0 pulses once, 6 cycles after sampling; latch 2 Q=1.
- Contention: req0 and req1 both high with addr0=0, d0=1, addr1=3, d1=0 → requester 0 served first, then requester 1; acks 7 cycles apart; pointer alternation holds over 4 back-to-back rounds.
- Invalid address: N_LATCH=3, addr1=3 → latch_c stays 0 for the whole sequence; ack1 and err pulse together.
- Mid-operation reset: rst_n=0 during PULSE → latch_c=0 after the next edge, no ack; the re-issued write then completes normally.
- Readback (macro defined): the bench model forces latch_q[1]=0 while writing d=1 to latch 1 → err pulses with ack0. Without the macro, the same stimulus → err stays 0.
